// File: rtl/z3_dma_master_if.sv
// Signal bundle between the Zorro III bus-master engine and its environment:
// the single-transfer request side from the SCSI DMA logic plus the Z3 bus pins.
interface z3_dma_master_if;
    // DMA request side
    logic        req;
    logic        rnw;
    logic [31:0] addr;
    logic [1:0]  siz;
    logic [31:0] wdata;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    // Zorro III bus side (asynchronous inputs are synchronised inside the engine)
    logic        br_n;
    logic        bg_n;
    logic        fcs_in_n;
    logic        dtack_n;
    logic        berr_n;
    logic        addr_oe;
    logic [31:0] addr_out;
    logic        fcs_n;
    logic        read;
    logic [3:0]  ds_n;
    logic        doe;
    logic        d_oe;
    logic [31:0] d_out;
    logic [31:0] d_in;

    modport master (
        input  req, rnw, addr, siz, wdata,
        input  bg_n, fcs_in_n, dtack_n, berr_n, d_in,
        output done, err, rdata,
        output br_n, addr_oe, addr_out, fcs_n, read, ds_n, doe, d_oe, d_out
    );

    modport slave (
        output req, rnw, addr, siz, wdata,
        output bg_n, fcs_in_n, dtack_n, berr_n, d_in,
        input  done, err, rdata,
        input  br_n, addr_oe, addr_out, fcs_n, read, ds_n, doe, d_oe, d_out
    );
endinterface

// File: rtl/z3_dma_master.sv
// Zorro III bus-master cycle engine: arbitrates, runs one full Z3 cycle per request, ends on DTACK/BERR.
// Optional macro Z3M_TIMEOUT_EN adds a WAIT_ACK watchdog that aborts after TIMEOUT_CYC cycles.
module z3_dma_master #(
    parameter int unsigned ADDR_SETUP  = 2,
    parameter int unsigned DS_DELAY    = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic            clk_i,
    input  logic            reset_i,
    z3_dma_master_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ASETUP,
        DSETUP,
        WAIT_ACK,
        TERM,
        RELEASE
    } state_e;

    if (ADDR_SETUP < 1 || ADDR_SETUP > 15) begin : g_bad_addr_setup
        $error("ADDR_SETUP must be within 1..15");
    end
    if (DS_DELAY < 1 || DS_DELAY > 15) begin : g_bad_ds_delay
        $error("DS_DELAY must be within 1..15");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    // ------------------------------------------------------------------
    // Two-flop synchronisers for the asynchronous bus inputs; idle = 1
    // ------------------------------------------------------------------
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= {bus.bg_n, bus.fcs_in_n, bus.dtack_n, bus.berr_n};
            sync2_q <= sync1_q;
        end
    end

    logic bg_s;
    logic fcs_in_s;
    logic dtack_s;
    logic berr_s;

    assign bg_s     = sync2_q[3];
    assign fcs_in_s = sync2_q[2];
    assign dtack_s  = sync2_q[1];
    assign berr_s   = sync2_q[0];

    // Active-low strobe for byte lanes a..min(a+n-1,3); byte k drives DS_n[3-k].
    function automatic logic [3:0] lane_strobes(input logic [1:0] a, input logic [1:0] siz);
        logic [2:0] last;
        logic [3:0] ds;
        last = {1'b0, a} + ((siz == 2'b00) ? 3'd3 : ({1'b0, siz} - 3'd1));
        if (last > 3'd3) begin
            last = 3'd3;
        end
        ds = 4'hF;
        for (int k = 0; k < 4; k++) begin
            if (k >= int'(a) && k <= int'(last)) begin
                ds[3-k] = 1'b0;
            end
        end
        return ds;
    endfunction

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_e      state_q,    state_d;
    logic [3:0]  cnt_q,      cnt_d;
    logic        rnw_q,      rnw_d;
    logic [1:0]  siz_q,      siz_d;
    logic        br_n_q,     br_n_d;
    logic        addr_oe_q,  addr_oe_d;
    logic [31:0] addr_out_q, addr_out_d;
    logic        fcs_n_q,    fcs_n_d;
    logic        read_q,     read_d;
    logic [3:0]  ds_n_q,     ds_n_d;
    logic        doe_q,      doe_d;
    logic        d_oe_q,     d_oe_d;
    logic [31:0] d_out_q,    d_out_d;
    logic        done_q,     done_d;
    logic        err_q,      err_d;
    logic [31:0] rdata_q,    rdata_d;
    logic        tmo_hit;

`ifdef Z3M_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Held at zero outside WAIT_ACK, so it starts fresh on every entry.
    always_comb begin
        tmo_d = '0;
        if (state_q == WAIT_ACK) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rnw_q      <= 1'b1;
            siz_q      <= '0;
            br_n_q     <= 1'b1;
            addr_oe_q  <= 1'b0;
            addr_out_q <= '0;
            fcs_n_q    <= 1'b1;
            read_q     <= 1'b1;
            ds_n_q     <= 4'hF;
            doe_q      <= 1'b0;
            d_oe_q     <= 1'b0;
            d_out_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rnw_q      <= rnw_d;
            siz_q      <= siz_d;
            br_n_q     <= br_n_d;
            addr_oe_q  <= addr_oe_d;
            addr_out_q <= addr_out_d;
            fcs_n_q    <= fcs_n_d;
            read_q     <= read_d;
            ds_n_q     <= ds_n_d;
            doe_q      <= doe_d;
            d_oe_q     <= d_oe_d;
            d_out_q    <= d_out_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    // NOTE: every signal gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rnw_d      = rnw_q;
        siz_d      = siz_q;
        br_n_d     = br_n_q;
        addr_oe_d  = addr_oe_q;
        addr_out_d = addr_out_q;
        fcs_n_d    = fcs_n_q;
        read_d     = read_q;
        ds_n_d     = ds_n_q;
        doe_d      = doe_q;
        d_oe_d     = d_oe_q;
        d_out_d    = d_out_q;
        done_d     = 1'b0;
        err_d      = err_q;
        rdata_d    = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    rnw_d      = bus.rnw;
                    siz_d      = bus.siz;
                    addr_out_d = bus.addr;
                    d_out_d    = bus.wdata;
                    br_n_d     = 1'b0;
                    state_d    = ARB;
                end
            end

            ARB: begin
                if (!bus.req) begin
                    br_n_d  = 1'b1;
                    state_d = IDLE;
                end else if (!bg_s && fcs_in_s && dtack_s) begin
                    // Granted and the previous owner has fully left the bus.
                    br_n_d    = 1'b1;
                    addr_oe_d = 1'b1;
                    read_d    = rnw_q;
                    cnt_d     = 4'(ADDR_SETUP);
                    state_d   = ASETUP;
                end
            end

            ASETUP: begin
                if (cnt_q == 4'd0) begin
                    fcs_n_d = 1'b0;
                    cnt_d   = 4'(DS_DELAY);
                    state_d = DSETUP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            DSETUP: begin
                if (cnt_q == 4'd0) begin
                    ds_n_d  = lane_strobes(addr_out_q[1:0], siz_q);
                    doe_d   = 1'b1;
                    d_oe_d  = ~rnw_q;
                    state_d = WAIT_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            WAIT_ACK: begin
                if (!berr_s || !dtack_s || tmo_hit) begin
                    // BERR beats DTACK; a DTACK arriving with the timeout still counts as success.
                    err_d   = !berr_s || (dtack_s && tmo_hit);
                    if (rnw_q && berr_s && !dtack_s) begin
                        rdata_d = bus.d_in;
                    end
                    ds_n_d  = 4'hF;
                    doe_d   = 1'b0;
                    d_oe_d  = 1'b0;
                    fcs_n_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = TERM;
                end
            end

            TERM: begin
                addr_oe_d = 1'b0;
                read_d    = 1'b1;
                state_d   = RELEASE;
            end

            RELEASE: begin
                if (dtack_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.rdata    = rdata_q;
    assign bus.br_n     = br_n_q;
    assign bus.addr_oe  = addr_oe_q;
    assign bus.addr_out = addr_out_q;
    assign bus.fcs_n    = fcs_n_q;
    assign bus.read     = read_q;
    assign bus.ds_n     = ds_n_q;
    assign bus.doe      = doe_q;
    assign bus.d_oe     = d_oe_q;
    assign bus.d_out    = d_out_q;

endmodule
